// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate generator for the decode stage.
// An output register plus one skid register sit behind valid/ready handshakes
// on both sides, and a flush input discards everything that is buffered.
// Optional feature macro: IMM_FMT_ERR_EN adds a fmt_err output that travels
// through the buffer together with each immediate.
//
// state | meaning
// EMPTY | no entries buffered, out_valid=0
// ONE   | output register holds an entry
// FULL  | output and skid registers both hold entries, in_ready=0
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       ctrl,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_FMT_ERR_EN
  ,
  output logic             fmt_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             in_fire, out_fire;
  logic             load_out_in, load_out_skid, load_skid;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_d;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             unused_opcode;

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // The opcode field never contributes to an immediate.
  assign unused_opcode = &{1'b0, inst[6:0]};

  // Every format fits in 32 bits with its sign in bit 31; SHAMT and ZIMM
  // leave bit 31 clear, so one sign extension to XLEN serves all formats.
  always_comb begin
    imm32 = 32'd0;
    case (ctrl)
      3'b000:  imm32 = {{20{inst[31]}}, inst[31:20]};
      3'b001:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'b010:  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'b011:  imm32 = {inst[31:12], 12'd0};
      3'b100:  imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'b101:  imm32 = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
      3'b110:  imm32 = {27'd0, inst[19:15]};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_d = XLEN'($signed(imm32));

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready && !flush;
  assign out_fire  = out_valid && out_ready;

  // State register; in_ready is registered from the next state so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  // Next-state and datapath load selection; flush overrides every event.
  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt   = ONE;
            load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_out_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt     = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output and skid registers; the output register holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm      <= '0;
      out_tag  <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else begin
      if (load_out_in) begin
        imm     <= imm_d;
        out_tag <= tag;
      end else if (load_out_skid) begin
        imm     <= skid_imm;
        out_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= imm_d;
        skid_tag <= tag;
      end
    end
  end

`ifdef IMM_FMT_ERR_EN
  logic err_d;
  logic skid_err;

  assign err_d = (ctrl == 3'b111) || ((ctrl == 3'b101) && (XLEN == 32) && inst[25]);

  // Format-error flag follows its immediate through the same registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_err  <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      if (load_out_in) begin
        fmt_err <= err_d;
      end else if (load_out_skid) begin
        fmt_err <= skid_err;
      end
      if (load_skid) begin
        skid_err <= err_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      inst = 32'd0;
  logic [2:0]       ctrl = 3'd0;
  logic [TAG_W-1:0] tag = '0;

  logic             in_ready, out_valid;
  logic [31:0]      imm;
  logic [TAG_W-1:0] out_tag;
  logic             in_ready64, out_valid64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] out_tag64;
`ifdef IMM_FMT_ERR_EN
  logic             fmt_err, fmt_err64;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .ctrl(ctrl), .tag(tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .out_tag(out_tag)
`ifdef IMM_FMT_ERR_EN
    , .fmt_err(fmt_err)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .ctrl(ctrl), .tag(tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64), .out_tag(out_tag64)
`ifdef IMM_FMT_ERR_EN
    , .fmt_err(fmt_err64)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag;
    logic             err32;
    logic             err64;
  } exp_t;

  exp_t q[$];

  function automatic longint sext(longint v, int bits);
    if (v >= (longint'(1) <<< (bits - 1))) return v - (longint'(1) <<< bits);
    return v;
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] c, int xlen);
    longint v;
    case (c)
      3'd0:    v = sext(longint'(i[31:20]), 12);
      3'd1:    v = sext(longint'({i[31:25], i[11:7]}), 12);
      3'd2:    v = sext(longint'({i[31], i[7], i[30:25], i[11:8]}) * 2, 13);
      3'd3:    v = sext(longint'(i[31:12]) * 4096, 32);
      3'd4:    v = sext(longint'({i[31], i[19:12], i[20], i[30:21]}) * 2, 21);
      3'd5:    v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd6:    v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'd0, v[31:0]};
    return v;
  endfunction

  function automatic logic ref_err(logic [31:0] i, logic [2:0] c, int xlen);
    return (c == 3'd7) || (c == 3'd5 && xlen == 32 && i[25]);
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Track the expected FIFO contents from the observed handshakes.
  always @(posedge clk or negedge rst_n) begin : model_upd
    exp_t e;
    logic [63:0] r;
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        r = ref_imm(inst, ctrl, 32);
        e.imm32 = r[31:0];
        e.imm64 = ref_imm(inst, ctrl, 64);
        e.tag   = tag;
        e.err32 = ref_err(inst, ctrl, 32);
        e.err64 = ref_err(inst, ctrl, 64);
        q.push_back(e);
      end
    end
  end

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid64", out_valid64, q.size() > 0);
      check("in_ready64", in_ready64, q.size() < 2);
      if (q.size() > 0) begin
        check("imm", imm, q[0].imm32);
        check("out_tag", out_tag, q[0].tag);
        check("imm64", imm64, q[0].imm64);
        check("out_tag64", out_tag64, q[0].tag);
`ifdef IMM_FMT_ERR_EN
        check("fmt_err", fmt_err, q[0].err32);
        check("fmt_err64", fmt_err64, q[0].err64);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs, return just after the following falling edge.
  task automatic drive(logic v, logic [31:0] i, logic [2:0] c, logic [TAG_W-1:0] t,
                       logic ordy, logic fl);
    in_valid  = v;
    inst      = i;
    ctrl      = c;
    tag       = t;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(logic ordy);
    drive(1'b0, 32'd0, 3'd0, '0, ordy, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset imm", imm, 32'd0);
    check("reset out_tag", out_tag, 8'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check("post-reset in_ready", in_ready, 1'b1);

    // Formats, out_ready=1, one cycle latency each
    drive(1, 32'hFFF00093, 3'd0, 8'h01, 1, 0);
    check("I imm", imm, 32'hFFFFFFFF);
    check("I valid", out_valid, 1'b1);
`ifdef IMM_FMT_ERR_EN
    check("I fmt_err", fmt_err, 1'b0);
`endif
    drive(1, 32'hFE112E23, 3'd1, 8'h02, 1, 0);
    check("S imm", imm, 32'hFFFFFFFC);
    drive(1, 32'hFE000CE3, 3'd2, 8'h03, 1, 0);
    check("B imm", imm, 32'hFFFFFFF8);
    drive(1, 32'hFFDFF06F, 3'd4, 8'h04, 1, 0);
    check("J imm", imm, 32'hFFFFFFFC);
    drive(1, 32'h123450B7, 3'd3, 8'h05, 1, 0);
    check("U imm", imm, 32'h12345000);
    check("U imm64", imm64, 64'h0000000012345000);
    drive(1, 32'h800000B7, 3'd3, 8'h06, 1, 0);
    check("U neg imm64", imm64, 64'hFFFFFFFF80000000);
    drive(1, 32'h02001093, 3'd5, 8'h07, 1, 0);
    check("SHAMT imm", imm, 32'h0);
    check("SHAMT imm64", imm64, 64'h20);
`ifdef IMM_FMT_ERR_EN
    check("SHAMT fmt_err", fmt_err, 1'b1);
    check("SHAMT fmt_err64", fmt_err64, 1'b0);
`endif
    drive(1, 32'h000F8073, 3'd6, 8'h08, 1, 0);
    check("ZIMM imm", imm, 32'h1F);
    drive(1, 32'hFFFFFFFF, 3'd7, 8'h09, 1, 0);
    check("RSV imm", imm, 32'h0);
`ifdef IMM_FMT_ERR_EN
    check("RSV fmt_err", fmt_err, 1'b1);
`endif
    idle(1);
    check("drain valid", out_valid, 1'b0);

    // Backpressure: tags 1,2 accepted, 3 waits at the input
    drive(1, 32'h00100093, 3'd0, 8'd1, 0, 0);
    check("bp t1 tag", out_tag, 8'd1);
    check("bp t1 ready", in_ready, 1'b1);
    drive(1, 32'h00200093, 3'd0, 8'd2, 0, 0);
    check("bp full ready", in_ready, 1'b0);
    check("bp hold tag", out_tag, 8'd1);
    drive(1, 32'h00300093, 3'd0, 8'd3, 0, 0);
    drive(1, 32'h00300093, 3'd0, 8'd3, 0, 0);
    check("bp stall imm", imm, 32'd1);
    check("bp stall tag", out_tag, 8'd1);
    drive(1, 32'h00300093, 3'd0, 8'd3, 1, 0);
    check("bp rel tag2", out_tag, 8'd2);
    check("bp rel imm2", imm, 32'd2);
    drive(1, 32'h00300093, 3'd0, 8'd3, 1, 0);
    check("bp rel tag3", out_tag, 8'd3);
    check("bp rel imm3", imm, 32'd3);
    idle(1);
    check("bp drained", out_valid, 1'b0);

    // Flush while FULL with a pending input
    drive(1, 32'h00400093, 3'd0, 8'd4, 0, 0);
    drive(1, 32'h00500093, 3'd0, 8'd5, 0, 0);
    check("fl full", in_ready, 1'b0);
    drive(1, 32'h00600093, 3'd0, 8'd6, 0, 1);
    check("fl valid", out_valid, 1'b0);
    check("fl ready", in_ready, 1'b1);
    drive(1, 32'h00700093, 3'd0, 8'd7, 1, 0);
    check("fl next tag", out_tag, 8'd7);
    check("fl next imm", imm, 32'd7);
    idle(1);

    // Asynchronous reset while FULL
    drive(1, 32'h00800093, 3'd0, 8'd8, 0, 0);
    drive(1, 32'h00900093, 3'd0, 8'd9, 0, 0);
    check("ar full", in_ready, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar valid", out_valid, 1'b0);
    check("ar imm", imm, 32'd0);
    check("ar imm64", imm64, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check("ar ready", in_ready, 1'b1);
    drive(1, 32'h00A00093, 3'd0, 8'd10, 1, 0);
    check("ar first tag", out_tag, 8'd10);
    check("ar first imm", imm, 32'd10);
    idle(1);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
